tl_axi_req_throttle: RTL and testbench

- Admission controller on the TL-UH A channel, placed in front of the TL-to-AXI bridge.
- Decides when each A request may enter the bridge. It enforces:
  - at most one in-flight transaction per TL source, since the AXI ID equals the source and the bridge tracks one entry per source;
  - a global cap on outstanding transactions;
  - no interleaving of a multi-beat write burst.
- Gates handshakes only; the payload bypasses the block.
- Retires transactions by observing the D channel.

---
 rtl/tl_axi_req_throttle.sv | 155 +++++++++++++++
 tb/tb_tl_axi_req_throttle.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_axi_req_throttle.sv
// TL-UH A-channel admission throttle for the TL-to-AXI bridge: zero-latency handshake gating, up_ready_o follows dn_ready_i when admissible.
// Define TL_AXI_THROTTLE_RAW_ORDER_EN to hold Gets until every admitted Put has retired.
module tl_axi_req_throttle #(
  parameter int  SourceWidth    = 1,
  parameter int  MaxOutstanding = 2,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   up_valid_i,
  output logic                   up_ready_o,
  input  logic [SourceWidth-1:0] up_source_i,
  input  logic                   up_is_read_i,
  input  logic                   up_first_i,
  input  logic                   up_last_i,
  output logic                   dn_valid_o,
  input  logic                   dn_ready_i,
  input  logic                   rsp_valid_i,
  input  logic                   rsp_ready_i,
  input  logic [SourceWidth-1:0] rsp_source_i,
  input  logic                   rsp_last_i,
  output logic [CntWidth-1:0]    outstanding_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int NumSrc = 2 ** SourceWidth;

  if (MaxOutstanding < 1 || MaxOutstanding > NumSrc) begin : g_bad_cfg
    $fatal(1, "tl_axi_req_throttle: MaxOutstanding must be in 1..2**SourceWidth");
  end

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NumSrc-1:0]   pending_q, pending_d;
  logic [NumSrc-1:0]   is_wr_q, is_wr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic allow;
  logic afire, admit, dfire, rsp_hit, retire;
  logic raw_ok;

`ifdef TL_AXI_THROTTLE_RAW_ORDER_EN
  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic                wr_inc, wr_dec;

  assign raw_ok = !up_is_read_i || (wr_cnt_q == '0);
  assign wr_inc = admit && !up_is_read_i;
  assign wr_dec = retire && is_wr_q[rsp_source_i];

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_inc && !wr_dec) begin
      wr_cnt_d = wr_cnt_q + CntWidth'(1);
    end else if (!wr_inc && wr_dec) begin
      wr_cnt_d = wr_cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end
`else
  logic unused_is_wr;
  assign raw_ok       = 1'b1;
  assign unused_is_wr = ^is_wr_q;
`endif

  // Continuation beats of an admitted write always pass; new messages see the per-source and global limits.
  always_comb begin
    allow = 1'b1;
    if (state_q == IDLE) begin
      allow = !pending_q[up_source_i] && (cnt_q < CntWidth'(MaxOutstanding)) && raw_ok;
    end
  end

  assign dn_valid_o = up_valid_i && allow;
  assign up_ready_o = dn_ready_i && allow;

  assign afire   = up_valid_i && up_ready_o;
  assign admit   = afire && up_first_i && (state_q == IDLE);
  assign dfire   = rsp_valid_i && rsp_ready_i && rsp_last_i;
  assign rsp_hit = pending_q[rsp_source_i];
  assign retire  = dfire && rsp_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (admit && !up_is_read_i && !up_last_i) begin
          state_d = WBURST;
        end
      end
      WBURST: begin
        if (afire && up_last_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Admit and retire never target the same source in one cycle, so the order below is safe.
  always_comb begin
    pending_d = pending_q;
    is_wr_d   = is_wr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (retire) begin
      pending_d[rsp_source_i] = 1'b0;
    end
    if (dfire && !rsp_hit) begin
      err_d = 1'b1;
    end
    if (admit) begin
      pending_d[up_source_i] = 1'b1;
      is_wr_d[up_source_i]   = !up_is_read_i;
    end
    if (admit && !retire) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!admit && retire) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      is_wr_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = (cnt_q != '0) || (state_q == WBURST);
  assign err_o         = err_q;

endmodule

// File: tb/tb_tl_axi_req_throttle.sv
// Directed bench for tl_axi_req_throttle with a scoreboard of expected downstream A-beat passes.
module tb_tl_axi_req_throttle;

  localparam int SW  = 2;
  localparam int MO  = 2;
  localparam int CW  = $clog2(MO + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          up_valid_i, up_ready_o;
  logic [SW-1:0] up_source_i;
  logic          up_is_read_i, up_first_i, up_last_i;
  logic          dn_valid_o, dn_ready_i;
  logic          rsp_valid_i, rsp_ready_i, rsp_last_i;
  logic [SW-1:0] rsp_source_i;
  logic [CW-1:0] outstanding_o;
  logic          busy_o, err_o;

  tl_axi_req_throttle #(
    .SourceWidth   (SW),
    .MaxOutstanding(MO)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .up_valid_i   (up_valid_i),
    .up_ready_o   (up_ready_o),
    .up_source_i  (up_source_i),
    .up_is_read_i (up_is_read_i),
    .up_first_i   (up_first_i),
    .up_last_i    (up_last_i),
    .dn_valid_o   (dn_valid_o),
    .dn_ready_i   (dn_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_source_i (rsp_source_i),
    .rsp_last_i   (rsp_last_i),
    .outstanding_o(outstanding_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int src;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every downstream beat that fires must match the next expected pass (source and cycle).
  always @(negedge clk_i) begin
    if (rst_ni && dn_valid_o && dn_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_pass", 32'(up_source_i), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pass_src", 32'(up_source_i), 32'(e.src));
        check("pass_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_pass(input int src);
    exp_t e;
    e.src = src;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic a_beat(input int src, input logic rd, input logic first, input logic last);
    up_valid_i   = 1'b1;
    up_source_i  = SW'(src);
    up_is_read_i = rd;
    up_first_i   = first;
    up_last_i    = last;
  endtask

  task automatic a_idle();
    up_valid_i = 1'b0;
  endtask

  task automatic d_beat(input int src);
    rsp_valid_i  = 1'b1;
    rsp_source_i = SW'(src);
    rsp_last_i   = 1'b1;
  endtask

  task automatic d_idle();
    rsp_valid_i = 1'b0;
  endtask

  task automatic retire(input int src);
    d_beat(src);
    tick();
    d_idle();
  endtask

  initial begin
    rst_ni       = 1'b0;
    up_valid_i   = 1'b0;
    up_source_i  = '0;
    up_is_read_i = 1'b1;
    up_first_i   = 1'b1;
    up_last_i    = 1'b1;
    dn_ready_i   = 1'b0;
    rsp_valid_i  = 1'b0;
    rsp_ready_i  = 1'b1;
    rsp_source_i = '0;
    rsp_last_i   = 1'b1;

    tick();
    tick();
    check("rst_outstanding", 32'(outstanding_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_err", 32'(err_o), 0);
    rst_ni = 1'b1;
    tick();

    // Basic read
    dn_ready_i = 1'b1;
    a_beat(0, 1, 1, 1);
    settle();
    check("basic_up_ready", 32'(up_ready_o), 1);
    check("basic_dn_valid", 32'(dn_valid_o), 1);
    expect_pass(0);
    tick();
    a_idle();
    check("basic_out1", 32'(outstanding_o), 1);
    check("basic_busy", 32'(busy_o), 1);
    retire(0);
    check("basic_out0", 32'(outstanding_o), 0);

    // Per-source block
    a_beat(0, 1, 1, 1);
    expect_pass(0);
    tick();
    settle();
    check("blk_ready0", 32'(up_ready_o), 0);
    check("blk_valid0", 32'(dn_valid_o), 0);
    tick();
    d_beat(0);
    settle();
    check("blk_ready_retire_cyc", 32'(up_ready_o), 0);
    tick();
    d_idle();
    settle();
    check("blk_ready_after", 32'(up_ready_o), 1);
    check("blk_out_bubble", 32'(outstanding_o), 0);
    expect_pass(0);
    tick();
    a_idle();
    check("blk_out1", 32'(outstanding_o), 1);
    retire(0);

    // Global cap
    a_beat(0, 1, 1, 1);
    expect_pass(0);
    tick();
    a_beat(1, 1, 1, 1);
    expect_pass(1);
    tick();
    a_beat(2, 1, 1, 1);
    settle();
    check("cap_out2", 32'(outstanding_o), 2);
    check("cap_held", 32'(up_ready_o), 0);
    d_beat(1);
    settle();
    check("cap_held_retire_cyc", 32'(dn_valid_o), 0);
    tick();
    d_idle();
    settle();
    check("cap_ready_after", 32'(up_ready_o), 1);
    expect_pass(2);
    tick();
    a_idle();
    check("cap_out_final", 32'(outstanding_o), 2);
    retire(0);
    retire(2);
    check("cap_drained", 32'(outstanding_o), 0);

    // Write burst at the cap
    a_beat(1, 1, 1, 1);
    expect_pass(1);
    tick();
    a_beat(0, 0, 1, 0);
    expect_pass(0);
    tick();
    check("wb_out2", 32'(outstanding_o), 2);
    check("wb_busy", 32'(busy_o), 1);
    for (int b = 1; b < 4; b++) begin
      a_beat(0, 0, 0, (b == 3));
      dn_ready_i = 1'b0;
      settle();
      check("wb_stall_ready", 32'(up_ready_o), 0);
      check("wb_stall_valid", 32'(dn_valid_o), 1);
      tick();
      dn_ready_i = 1'b1;
      settle();
      check("wb_cont_ready", 32'(up_ready_o), 1);
      expect_pass(0);
      tick();
    end
    a_beat(3, 1, 1, 1);
    settle();
    check("wb_idle_capped", 32'(up_ready_o), 0);
    a_idle();
    retire(0);
    retire(1);
    check("wb_drained", 32'(outstanding_o), 0);
    check("wb_not_busy", 32'(busy_o), 0);

    // Simultaneous admit/retire and stray response
    a_beat(0, 1, 1, 1);
    expect_pass(0);
    tick();
    a_beat(1, 1, 1, 1);
    d_beat(0);
    expect_pass(1);
    tick();
    a_idle();
    d_idle();
    check("sim_out_unchanged", 32'(outstanding_o), 1);
    check("sim_err_clear", 32'(err_o), 0);
    retire(3);
    check("stray_err", 32'(err_o), 1);
    check("stray_out", 32'(outstanding_o), 1);
    retire(1);
    tick();
    check("stray_err_sticky", 32'(err_o), 1);
    check("stray_out0", 32'(outstanding_o), 0);

    // Non-first beat in IDLE passes but admits nothing
    a_beat(2, 1, 0, 1);
    expect_pass(2);
    tick();
    a_idle();
    check("nofirst_out", 32'(outstanding_o), 0);
    check("nofirst_busy", 32'(busy_o), 0);

    // Read after write
    a_beat(0, 0, 1, 1);
    expect_pass(0);
    tick();
    a_beat(1, 1, 1, 1);
    settle();
`ifdef TL_AXI_THROTTLE_RAW_ORDER_EN
    check("raw_held", 32'(up_ready_o), 0);
    d_beat(0);
    settle();
    check("raw_held_retire_cyc", 32'(up_ready_o), 0);
    tick();
    d_idle();
    settle();
    check("raw_released", 32'(up_ready_o), 1);
    expect_pass(1);
    tick();
    a_idle();
    retire(1);
`else
    check("raw_free", 32'(up_ready_o), 1);
    expect_pass(1);
    tick();
    a_idle();
    check("raw_out2", 32'(outstanding_o), 2);
    retire(0);
    retire(1);
`endif
    check("raw_drained", 32'(outstanding_o), 0);

    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("final_rst_err", 32'(err_o), 0);
    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
